// File: rtl/mds_rs_engine.sv
// Byte-serial GF(2^8) matrix-vector engine for the Twofish core.
// Mode 0 multiplies a 4-byte vector by the 4x4 MDS matrix over MDS_POLY.
// Mode 1 multiplies an 8-byte vector by the 4x8 RS matrix over RS_POLY.
// BYTES_PER_CYCLE input bytes are folded into the accumulator per BUSY cycle.
module mds_rs_engine #(
  parameter int unsigned BYTES_PER_CYCLE = 1,
  parameter logic [8:0]  MDS_POLY        = 9'h169,
  parameter logic [8:0]  RS_POLY         = 9'h14D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bpc_check
    $error("mds_rs_engine: BYTES_PER_CYCLE must be 1, 2 or 4");
  end

  // Matrix rows packed with column k in byte k.
  localparam logic [31:0] MDS_R0 = 32'h5B5BEF01;
  localparam logic [31:0] MDS_R1 = 32'h01EFEF5B;
  localparam logic [31:0] MDS_R2 = 32'hEF015BEF;
  localparam logic [31:0] MDS_R3 = 32'h5BEF01EF;
  localparam logic [63:0] RS_R0  = 64'h9EDB585A8755A401;
  localparam logic [63:0] RS_R1  = 64'hE568C61EF38256A4;
  localparam logic [63:0] RS_R2  = 64'h193DAE47C1FCA102;
  localparam logic [63:0] RS_R3  = 64'h039EDB585A8755A4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic        mode_q, mode_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  idx_q, idx_d;
  logic        last_beat;

  // Shift-and-add GF(2^8) multiply, reducing with the low 8 bits of poly.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] poly);
    logic [7:0] x;
    logic [7:0] bb;
    logic [7:0] res;
    x   = a;
    bb  = b;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) res = res ^ x;
      x  = {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
      bb = bb >> 1;
    end
    return res;
  endfunction

  // Matrix coefficient M[r][k] for the given mode.
  function automatic logic [7:0] coef(input logic mode, input int unsigned r,
                                      input int unsigned k);
    logic [63:0] row;
    logic [63:0] sh;
    if (mode) begin
      case (r)
        0:       row = RS_R0;
        1:       row = RS_R1;
        2:       row = RS_R2;
        default: row = RS_R3;
      endcase
    end else begin
      case (r)
        0:       row = {32'h0, MDS_R0};
        1:       row = {32'h0, MDS_R1};
        2:       row = {32'h0, MDS_R2};
        default: row = {32'h0, MDS_R3};
      endcase
    end
    sh = row >> (8 * k);
    return sh[7:0];
  endfunction

  // Contribution of bytes idx..idx+BPC-1 to all four output rows.
  function automatic logic [31:0] beat_contrib(input logic mode, input logic [63:0] data,
                                               input logic [2:0] idx);
    logic [31:0]  acc;
    logic [63:0]  sh;
    logic [7:0]   b;
    logic [7:0]   poly;
    int unsigned  k;
    acc  = '0;
    poly = mode ? RS_POLY[7:0] : MDS_POLY[7:0];
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      k  = 32'(idx) + j;
      sh = data >> (8 * k);
      b  = sh[7:0];
      for (int unsigned r = 0; r < 4; r++) begin
        acc = acc ^ (32'(gf_mul(coef(mode, r, k), b, poly)) << (8 * r));
      end
    end
    return acc;
  endfunction

  // Final beat when this beat consumes the last column of the latched mode.
  assign last_beat = ({1'b0, idx_q} + 4'(BYTES_PER_CYCLE)) == (mode_q ? 4'd8 : 4'd4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_BUSY;
      ST_BUSY: if (last_beat) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath next values: latch at accept, accumulate while busy.
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = in_mode;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      ST_BUSY: begin
        acc_d = acc_q ^ beat_contrib(mode_q, data_q, idx_q);
        // Index holds on the final beat so it never reaches 8.
        if (!last_beat) idx_d = idx_q + 3'(BYTES_PER_CYCLE);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
    end
  end

  assign out_data = acc_q;

endmodule

// File: tb/tb_mds_rs_engine.sv
// Bench for mds_rs_engine: three instances (BPC = 1, 2, 4) share one stimulus
// stream and are each checked every cycle against a GF(2^8) reference model.
module tb_mds_rs_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [31:0] out_data_w [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mds_rs_engine #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_data  (out_data_w[g])
    );
  end

  // Reference matrices, row-major [r][k].
  logic [7:0] mds_t [4][4] = '{'{8'h01, 8'hEF, 8'h5B, 8'h5B},
                              '{8'h5B, 8'hEF, 8'hEF, 8'h01},
                              '{8'hEF, 8'h5B, 8'h01, 8'hEF},
                              '{8'hEF, 8'h01, 8'hEF, 8'h5B}};
  logic [7:0] rs_t [4][8] = '{'{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
                             '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
                             '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
                             '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}};

  // Carry-less product followed by polynomial long division.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b,
                                      input logic [8:0] poly);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 8'h1) != 8'h0) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 16'h1) != 16'h0) p = p ^ (16'(poly) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_vec(input logic mode, input logic [63:0] d);
    logic [31:0] res;
    logic [7:0]  m;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < (mode ? 8 : 4); k++) begin
        m   = mode ? rs_t[r][k] : mds_t[r][k];
        res = res ^ (32'(gmul(m, 8'(d >> (8 * k)), mode ? 9'h14D : 9'h169)) << (8 * r));
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
  endtask

  // Per-instance transaction model: pending request, cycles since accept,
  // beats needed, expected result, and whether out_data must read zero.
  bit          m_pend [3] = '{0, 0, 0};
  int          m_age  [3] = '{0, 0, 0};
  int          m_n    [3] = '{1, 1, 1};
  logic [31:0] m_exp  [3];
  bit          m_zero [3] = '{1, 1, 1};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pend[i] <= 1'b0;
        m_age[i]  <= 0;
        m_zero[i] <= 1'b1;
      end else if (!m_pend[i]) begin
        if (in_valid) begin
          m_pend[i] <= 1'b1;
          m_age[i]  <= 0;
          m_n[i]    <= (in_mode ? 8 : 4) / (1 << i);
          m_exp[i]  <= ref_vec(in_mode, in_data);
          m_zero[i] <= 1'b0;
        end
      end else if (m_age[i] >= m_n[i]) begin
        if (out_ready) m_pend[i] <= 1'b0;
      end else begin
        m_age[i] <= m_age[i] + 1;
      end
    end
  end

  // Compare every instance against the model once per cycle.
  always @(negedge clk) begin
    bit ev;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      ev = m_pend[i] && (m_age[i] >= m_n[i]);
      chk($sformatf("in_ready[bpc%0d]", 1 << i), 64'(in_ready_w[i]), 64'(!m_pend[i]));
      chk($sformatf("out_valid[bpc%0d]", 1 << i), 64'(out_valid_w[i]), 64'(ev));
      if (ev)
        chk($sformatf("out_data[bpc%0d]", 1 << i), 64'(out_data_w[i]), 64'(m_exp[i]));
      else if (m_zero[i])
        chk($sformatf("out_data_zero[bpc%0d]", 1 << i), 64'(out_data_w[i]), 64'h0);
    end
  end

  task automatic wait_all_idle();
    int t;
    t = 0;
    while (in_ready_w != 3'b111) begin
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        timeout("wait_idle");
        return;
      end
    end
  endtask

  task automatic wait_all_valid();
    int t;
    t = 0;
    while (out_valid_w != 3'b111) begin
      @(posedge clk); #1;
      t++;
      if (t > 30) begin
        timeout("wait_valid");
        return;
      end
    end
  endtask

  // Directed request held in DONE while checked against a literal.
  task automatic lit_req(input string name, input logic m, input logic [63:0] d,
                         input logic [31:0] e);
    wait_all_idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = ~m;
    in_data  = ~d;
    wait_all_valid();
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s[bpc%0d]", name, 1 << i), 64'(out_data_w[i]), 64'(e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Pin the reference model to hand-computed values.
    chk("model_mds_e0",  64'(ref_vec(1'b0, 64'h1)), 64'hEFEF5B01);
    chk("model_mds_x3",  64'(ref_vec(1'b0, 64'h3)), 64'h5858ED03);
    chk("model_rs_e7",   64'(ref_vec(1'b1, 64'h0100_0000_0000_0000)), 64'h0319E59E);
    chk("model_gmul",    64'(gmul(8'hEF, 8'h02, 9'h169)), 64'hB7);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready[bpc%0d]", 1 << i), 64'(in_ready_w[i]), 64'h1);
      chk($sformatf("rst_out_valid[bpc%0d]", 1 << i), 64'(out_valid_w[i]), 64'h0);
      chk($sformatf("rst_out_data[bpc%0d]", 1 << i), 64'(out_data_w[i]), 64'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors; inputs are scrambled right after accept.
    lit_req("mds_e0",   1'b0, 64'h1, 32'hEFEF5B01);
    lit_req("mds_e1",   1'b0, 64'h100, 32'h015BEFEF);
    lit_req("mds_x3",   1'b0, 64'h3, 32'h5858ED03);
    lit_req("rs_e0",    1'b1, 64'h1, 32'hA402A401);
    lit_req("rs_e7",    1'b1, 64'h0100_0000_0000_0000, 32'h0319E59E);
    lit_req("rs_zero",  1'b1, 64'h0, 32'h0);
    lit_req("mds_zero", 1'b0, 64'h0, 32'h0);
    lit_req("mds_hi_ignored", 1'b0, 64'hFFFF_FFFF_0000_0000, 32'h0);

    // Backpressure: stay in DONE ten cycles with a competing request pending.
    wait_all_idle();
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 64'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_all_valid();
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_data  = 64'h0123_4567_89AB_CDEF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(in_ready_w), 64'h0);
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp_hold[bpc%0d]", 1 << i), 64'(out_data_w[i]), 64'hEFEF5B01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_all_idle();

    // Back-to-back burst with the request held and data changing every cycle.
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      in_valid = 1'b1;
      in_mode  = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_all_idle();

    // Single random requests under random output backpressure.
    for (int n = 0; n < 30; n++) begin
      int t;
      wait_all_idle();
      in_valid = 1'b1;
      in_mode  = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mode  = ~in_mode;
      in_data  = {$urandom, $urandom};
      t = 0;
      while (in_ready_w != 3'b111 && t < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        t++;
      end
      out_ready = 1'b0;
    end
    wait_all_idle();

    // Asynchronous reset in the middle of an operation.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_data   = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_out_valid[bpc%0d]", 1 << i), 64'(out_valid_w[i]), 64'h0);
      chk($sformatf("abort_out_data[bpc%0d]", 1 << i), 64'(out_data_w[i]), 64'h0);
      chk($sformatf("abort_in_ready[bpc%0d]", 1 << i), 64'(in_ready_w[i]), 64'h1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    lit_req("post_rst_rs_e0", 1'b1, 64'h1, 32'hA402A401);
    wait_all_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
